// File: rtl/demux_rr_dispatch_if.sv
// Handshake bundle for demux_rr_dispatch: one input stream
// fanned out to two output streams.
interface demux_rr_dispatch_if #(
   parameter int width = 8
);
   logic [width-1:0] i;
   logic             i_valid;
   logic             i_ready;
   logic             sel;
   logic             mode;
   logic [width-1:0] o0;
   logic             o0_valid;
   logic             o0_ready;
   logic [width-1:0] o1;
   logic             o1_valid;
   logic             o1_ready;

   modport master (
      output i, i_valid, sel, mode,
      output o0_ready, o1_ready,
      input  i_ready,
      input  o0, o0_valid,
      input  o1, o1_valid
   );

   modport slave (
      input  i, i_valid, sel, mode,
      input  o0_ready, o1_ready,
      output i_ready,
      output o0, o0_valid,
      output o1, o1_valid
   );
endinterface

// File: rtl/demux_rr_dispatch.sv
// Two-way demux into 2-entry FIFOs, explicit or round-robin routing.
// Optional pop counters cnt0/cnt1 under DEMUX_DISPATCH_CNT_EN.
module demux_rr_dispatch #(
   parameter int width = 8,
   parameter int depth = 2
) (
   input  logic clk,
   input  logic rst,
`ifdef DEMUX_DISPATCH_CNT_EN
   output logic [7:0] cnt0,
   output logic [7:0] cnt1,
`endif
   demux_rr_dispatch_if.slave bus
);

   logic             rr_q;
   logic             tgt;
   logic             acc;
   logic [1:0]       cnt_q [2];
   logic [width-1:0] mem_q [2][2];
   logic [1:0]       full;
   logic [1:0]       push;
   logic [1:0]       pop;

   // Target selection, flow control and per-channel push/pop strobes
   always_comb begin
      tgt = bus.mode ? rr_q : bus.sel;
      full[0] = (cnt_q[0] == 2'(depth));
      full[1] = (cnt_q[1] == 2'(depth));
      bus.i_ready = !full[tgt];
      acc = bus.i_valid && bus.i_ready;
      push[0] = acc && !tgt;
      push[1] = acc && tgt;
      pop[0] = (cnt_q[0] != 2'd0) && bus.o0_ready;
      pop[1] = (cnt_q[1] != 2'd0) && bus.o1_ready;
   end

   // Head words are masked to zero while a FIFO is empty
   always_comb begin
      bus.o0_valid = (cnt_q[0] != 2'd0);
      bus.o1_valid = (cnt_q[1] != 2'd0);
      bus.o0 = bus.o0_valid ? mem_q[0][0] : '0;
      bus.o1 = bus.o1_valid ? mem_q[1][0] : '0;
   end

   // Occupancy counts and round-robin pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q[0] <= 2'd0;
         cnt_q[1] <= 2'd0;
         rr_q <= 1'b0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            unique case ({push[c], pop[c]})
               2'b10:   cnt_q[c] <= cnt_q[c] + 2'd1;
               2'b01:   cnt_q[c] <= cnt_q[c] - 2'd1;
               default: cnt_q[c] <= cnt_q[c];
            endcase
         end
         if (acc && bus.mode)
            rr_q <= ~rr_q;
      end
   end

   // Storage: entry 0 is the head; a pop shifts entry 1 forward
   always_ff @(posedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (push[c] && pop[c])
            mem_q[c][0] <= bus.i;
         else if (pop[c])
            mem_q[c][0] <= mem_q[c][1];
         else if (push[c])
            mem_q[c][cnt_q[c][0]] <= bus.i;
      end
   end

`ifdef DEMUX_DISPATCH_CNT_EN
   // Saturating per-channel pop counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0 <= 8'd0;
         cnt1 <= 8'd0;
      end else begin
         if (pop[0] && cnt0 != 8'hff)
            cnt0 <= cnt0 + 8'd1;
         if (pop[1] && cnt1 != 8'hff)
            cnt1 <= cnt1 + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_demux_rr_dispatch.sv
// Scoreboard bench for demux_rr_dispatch: directed scenarios
// followed by randomized traffic against a queue-based model.
module tb_demux_rr_dispatch;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int nchk = 0;
   int nfail = 0;

   demux_rr_dispatch_if #(.width(8)) bus ();

`ifdef DEMUX_DISPATCH_CNT_EN
   logic [7:0] cnt0;
   logic [7:0] cnt1;
`endif

   demux_rr_dispatch #(.width(8), .depth(2)) dut (
      .clk(clk),
      .rst(rst),
`ifdef DEMUX_DISPATCH_CNT_EN
      .cnt0(cnt0),
      .cnt1(cnt1),
`endif
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference model: one queue per channel holds exactly
   // the words the FIFO should contain, head first.
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   bit rr = 1'b0;
   int pc0 = 0;
   int pc1 = 0;

   task automatic chk(string n, int act, int exp);
      nchk++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   // Monitor: compare DUT against model, then advance model
   always @(negedge clk) begin : mon
      bit t;
      bit er;
      if (rst) begin
         q0.delete();
         q1.delete();
         rr = 1'b0;
         pc0 = 0;
         pc1 = 0;
         chk("rst_o0_valid", int'(bus.o0_valid), 0);
         chk("rst_o1_valid", int'(bus.o1_valid), 0);
         chk("rst_o0", int'(bus.o0), 0);
         chk("rst_o1", int'(bus.o1), 0);
         chk("rst_i_ready", int'(bus.i_ready), 1);
      end else begin
         t = bus.mode ? rr : bus.sel;
         er = t ? (q1.size() < 2) : (q0.size() < 2);
         chk("i_ready", int'(bus.i_ready), int'(er));
         chk("o0_valid", int'(bus.o0_valid),
             int'(q0.size() != 0));
         chk("o1_valid", int'(bus.o1_valid),
             int'(q1.size() != 0));
         chk("o0", int'(bus.o0),
             q0.size() != 0 ? int'(q0[0]) : 0);
         chk("o1", int'(bus.o1),
             q1.size() != 0 ? int'(q1[0]) : 0);
`ifdef DEMUX_DISPATCH_CNT_EN
         chk("cnt0", int'(cnt0), pc0);
         chk("cnt1", int'(cnt1), pc1);
`endif
         if (q0.size() != 0 && bus.o0_ready) begin
            void'(q0.pop_front());
            if (pc0 < 255) pc0++;
         end
         if (q1.size() != 0 && bus.o1_ready) begin
            void'(q1.pop_front());
            if (pc1 < 255) pc1++;
         end
         if (bus.i_valid && er) begin
            if (t) q1.push_back(bus.i);
            else q0.push_back(bus.i);
            if (bus.mode) rr = ~rr;
         end
      end
   end

   task automatic cyc(bit v, logic [7:0] d, bit s, bit m,
                      bit r0, bit r1);
      @(posedge clk);
      #1;
      bus.i_valid = v;
      bus.i = d;
      bus.sel = s;
      bus.mode = m;
      bus.o0_ready = r0;
      bus.o1_ready = r1;
   endtask

   task automatic drain();
      for (int k = 0; k < 4; k++)
         cyc(0, 8'h00, 0, 0, 1, 1);
   endtask

   // Asynchronous reset asserted mid-cycle
   task automatic rst_pulse();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_o0_valid", int'(bus.o0_valid), 0);
      chk("arst_o1_valid", int'(bus.o1_valid), 0);
      chk("arst_o0", int'(bus.o0), 0);
      chk("arst_o1", int'(bus.o1), 0);
      chk("arst_i_ready", int'(bus.i_ready), 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.i_valid = 1'b0;
      bus.o0_ready = 1'b0;
      bus.o1_ready = 1'b0;
   endtask

   initial begin
      bus.i = 8'h00;
      bus.i_valid = 1'b0;
      bus.sel = 1'b0;
      bus.mode = 1'b0;
      bus.o0_ready = 1'b0;
      bus.o1_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Explicit routing to channel 0
      cyc(1, 8'hA0, 0, 0, 0, 0);
      cyc(0, 8'h00, 0, 0, 0, 0);
      cyc(0, 8'h00, 0, 0, 0, 0);
      drain();

      // Channel 1 fills; third word stalls
      cyc(1, 8'hB0, 1, 0, 0, 0);
      cyc(1, 8'hB1, 1, 0, 0, 0);
      cyc(1, 8'hB2, 1, 0, 0, 0);
      cyc(1, 8'hB2, 1, 0, 0, 0);
      cyc(1, 8'hB2, 1, 0, 0, 1);
      cyc(0, 8'h00, 1, 0, 0, 1);
      cyc(0, 8'h00, 1, 0, 0, 1);
      drain();

      // Round-robin from reset
      rst_pulse();
      cyc(1, 8'h10, 0, 1, 1, 1);
      cyc(1, 8'h11, 0, 1, 1, 1);
      cyc(1, 8'h12, 0, 1, 1, 1);
      cyc(1, 8'h13, 0, 1, 1, 1);
      drain();

      // Strict round-robin stall on full channel 0
      rst_pulse();
      cyc(1, 8'h20, 0, 1, 0, 1);
      cyc(1, 8'h21, 0, 1, 0, 1);
      cyc(1, 8'h22, 0, 1, 0, 1);
      cyc(1, 8'h23, 0, 1, 0, 1);
      cyc(1, 8'h24, 0, 1, 0, 1);
      cyc(1, 8'h24, 0, 1, 0, 1);
      cyc(1, 8'h24, 0, 1, 1, 1);
      cyc(1, 8'h24, 0, 1, 0, 1);
      cyc(0, 8'h00, 0, 1, 0, 1);
      drain();

      // Both channels full, then reset mid-cycle
      cyc(1, 8'hC0, 0, 0, 0, 0);
      cyc(1, 8'hC1, 0, 0, 0, 0);
      cyc(1, 8'hD0, 1, 0, 0, 0);
      cyc(1, 8'hD1, 1, 0, 0, 0);
      rst_pulse();
      cyc(1, 8'hE0, 0, 1, 0, 0);
      cyc(1, 8'hE1, 0, 1, 0, 0);
      cyc(0, 8'h00, 0, 1, 0, 0);
      drain();

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         cyc(1'($urandom_range(0, 1)),
             8'($urandom),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 2) != 0),
             1'($urandom_range(0, 2) != 0));
         if (k == 1500) rst_pulse();
      end
      drain();

      // Pop counter saturation on channel 0 only
      rst_pulse();
      for (int k = 0; k < 310; k++)
         cyc(1, 8'(k), 0, 0, 1, 0);
      drain();
`ifdef DEMUX_DISPATCH_CNT_EN
      @(negedge clk);
      chk("sat_cnt0", int'(cnt0), 255);
      chk("sat_cnt1", int'(cnt1), 0);
`endif
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule

// File: doc/demux_rr_dispatch.md
DEMUX_RR_DISPATCH -- requirements
Module: demux_rr_dispatch

Interface
REQ-001 Parameter: width, default 8, data word width in bits.
REQ-002 Parameter: depth, default 2, entries per output FIFO; fixed at 2 in this revision.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: i  input  width  input data word.
REQ-006 Port: i_valid  input  1  input word present.
REQ-007 Port: i_ready  output  1  block can accept the input word this cycle.
REQ-008 Port: sel  input  1  explicit target channel, used when mode=0 (0 selects o0, 1 selects o1).
REQ-009 Port: mode  input  1  0 selects explicit routing by sel; 1 selects round-robin routing.
REQ-010 Port: o0, o1  output  width each  head word of channel 0 and channel 1 FIFO.
REQ-011 Port: o0_valid, o1_valid  output  1 each  channel FIFO is non-empty.
REQ-012 Port: o0_ready, o1_ready  input  1 each  downstream consumes the channel head this cycle.

Function
REQ-013 Target channel: target = mode ? rr_ptr : sel; rr_ptr is a 1-bit internal register.
REQ-014 i_ready shall be 1 exactly when the target FIFO is not full; it is combinational from state, mode and sel.
REQ-015 Accept condition: i_valid && i_ready; on that edge, i shall be written to the tail of the target FIFO.
REQ-016 Latency: an accepted word shall appear on oX with oX_valid=1 on the cycle after acceptance if that FIFO was empty.
REQ-017 oX_valid shall equal (FIFO X count != 0); oX shall equal the FIFO X head, and shall be all zeros while that FIFO is empty.
REQ-018 Pop condition: oX_valid && oX_ready pops the head on that edge; oX_ready while the FIFO is empty has no effect.
REQ-019 Each FIFO preserves order; its count is in the range 0..2.
REQ-020 Push and pop on the same FIFO in the same cycle (count 1) shall leave the count unchanged and pass the words through in order.
REQ-021 Full FIFO: there is no bypass; i_ready=0 even if oX_ready=1 in that cycle, and the input word is held upstream.
REQ-022 Both channels may pop in the same cycle, independently of input activity.
REQ-023 rr_ptr shall toggle only on an accepted word while mode=1; it holds while mode=0 and while no word is accepted.
REQ-024 Round-robin is strict: when the rr target is full, the block stalls and does not skip to the other channel.
REQ-025 Changes to mode or sel take effect on target in the same cycle and do not alter stored data.

Reset
REQ-026 rst=1 shall asynchronously empty both FIFOs and clear rr_ptr to 0.
REQ-027 During reset: o0=o1=0, o0_valid=o1_valid=0, and i_ready=1.
REQ-028 Reset mid-operation discards all buffered words; no word accepted before reset appears afterwards.
REQ-029 First accept is possible on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro DEMUX_DISPATCH_CNT_EN, when defined, adds output ports cnt0 and cnt1 (8 bits each).
REQ-031 With DEMUX_DISPATCH_CNT_EN, cntX increments on each pop of channel X, saturates at 255, and is cleared by rst.
REQ-032 Without DEMUX_DISPATCH_CNT_EN, the cnt ports and their logic do not exist, and all other behaviour is identical.

Verification
REQ-033 mode=0, sel=0, i=8'hA0 valid one cycle, o0_ready=0 -> next cycle o0=8'hA0, o0_valid=1, o1_valid=0.
REQ-034 mode=0, sel=1, push 8'hB0, 8'hB1, 8'hB2 back-to-back with o1_ready=0 -> i_ready=0 on the third cycle; o1 holds 8'hB0; after two pops o1 shows 8'hB1 then 8'hB2.
REQ-035 mode=1 from reset, push 8'h10, 8'h11, 8'h12, 8'h13 with both readies=1 -> o0 sees 8'h10 then 8'h12; o1 sees 8'h11 then 8'h13.
REQ-036 mode=1, FIFO0 full, rr_ptr=0, FIFO1 empty -> i_ready=0; pulsing o0_ready for one cycle -> i_ready=1 and the word goes to channel 0.
REQ-037 Two words buffered on each channel, rst pulsed asynchronously mid-cycle -> all valids drop immediately, outputs read 0, rr_ptr=0, i_ready=1.
REQ-038 With DEMUX_DISPATCH_CNT_EN, 300 pops on channel 0 -> cnt0=255 and cnt1=0.
